// File: rtl/kvs_port_arb.sv
// Purpose     : round-robin arbiter funnelling NPORT key/flag request ports into one database port,
//               routing in-order database results back to the originating port via a tag FIFO.
// Latency     : 1 cycle request->db_valid, 1 cycle db_out_valid->out_valid.
// Backpressure: in_ready is one-hot to the round-robin winner and drops while TAG_DEPTH tags are outstanding.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   in_key/in_flag/in_valid per-port requests (port p at [p*W +: W]); in_ready per-port accept
//   db_key/db_flag/db_valid registered request to the database
//   db_out_valid/db_out_flag in-order database results
//   out_valid/out_flag      registered per-port results
//   err_orphan              sticky: a result arrived with no outstanding tag
//   req_cnt                 per-port accepted-request counters (32 bits each)
// Build option: define KVS_ARB_STATS_EN to enable the saturating req_cnt counters (else req_cnt is 0).
module kvs_port_arb #(
    parameter int NPORT     = 2,
    parameter int KEY_SIZE  = 96,
    parameter int FLAG_SIZE = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NPORT*KEY_SIZE-1:0]  in_key,
    input  logic [NPORT*FLAG_SIZE-1:0] in_flag,
    input  logic [NPORT-1:0]           in_valid,
    output logic [NPORT-1:0]           in_ready,
    output logic [KEY_SIZE-1:0]        db_key,
    output logic [FLAG_SIZE-1:0]       db_flag,
    output logic                       db_valid,
    input  logic                       db_out_valid,
    input  logic [FLAG_SIZE-1:0]       db_out_flag,
    output logic [NPORT-1:0]           out_valid,
    output logic [NPORT*FLAG_SIZE-1:0] out_flag,
    output logic                       err_orphan,
    output logic [NPORT*32-1:0]        req_cnt
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = $clog2(TAG_DEPTH);

    logic [PW-1:0]  rr_ptr;
    logic [TW:0]    count;
    logic [TW-1:0]  wr_ptr;
    logic [TW-1:0]  rd_ptr;
    logic [PW-1:0]  tag_mem [TAG_DEPTH];
    logic [PW-1:0]  head_tag;

    logic [NPORT-1:0]     rot_valid;
    logic                 found;
    logic [PW:0]          win_sum;
    logic [PW-1:0]        win_idx;
    logic [NPORT-1:0]     grant;
    logic                 can_push;
    logic                 xfer;
    logic                 pop;
    logic [KEY_SIZE-1:0]  win_key;
    logic [FLAG_SIZE-1:0] win_flag;

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign can_push = rst_n && (count < (TW+1)'(TAG_DEPTH));

    // Rotate the valids so bit 0 is the port at rr_ptr, take the first set bit,
    // then map the offset back to an absolute port index modulo NPORT.
    always_comb begin
        rot_valid = NPORT'({in_valid, in_valid} >> rr_ptr);
        found     = 1'b0;
        win_sum   = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!found && rot_valid[i]) begin
                found   = 1'b1;
                win_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            end
        end
        if (win_sum >= (PW+1)'(NPORT)) begin
            win_sum = win_sum - (PW+1)'(NPORT);
        end
        win_idx = win_sum[PW-1:0];
        grant   = '0;
        if (found && can_push) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign in_ready = grant;
    assign xfer     = |grant;
    assign pop      = db_out_valid && (count != '0);
    assign head_tag = tag_mem[rd_ptr];

    always_comb begin
        win_key  = '0;
        win_flag = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
                win_key  = in_key[p*KEY_SIZE +: KEY_SIZE];
                win_flag = in_flag[p*FLAG_SIZE +: FLAG_SIZE];
            end
        end
    end

    // Tag storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (xfer) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_valid   <= 1'b0;
            db_key     <= '0;
            db_flag    <= '0;
            out_valid  <= '0;
            out_flag   <= '0;
            err_orphan <= 1'b0;
            rr_ptr     <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            db_valid <= xfer;
            if (xfer) begin
                db_key  <= win_key;
                db_flag <= win_flag;
                rr_ptr  <= (win_idx == PW'(NPORT-1)) ? '0 : win_idx + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({xfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            out_valid <= '0;
            for (int p = 0; p < NPORT; p++) begin
                if (pop && head_tag == PW'(p)) begin
                    out_valid[p]                       <= 1'b1;
                    out_flag[p*FLAG_SIZE +: FLAG_SIZE] <= db_out_flag;
                end
            end
            if (db_out_valid && count == '0) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef KVS_ARB_STATS_EN
    logic [31:0] cnt_q [NPORT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPORT; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (grant[p] && cnt_q[p] != 32'hFFFF_FFFF) begin
                    cnt_q[p] <= cnt_q[p] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_cnt
        assign req_cnt[g*32 +: 32] = cnt_q[g];
    end
`else
    assign req_cnt = '0;
`endif

endmodule

// File: doc/kvs_port_arb.md
KVS_PORT_ARB -- requirements
Module: kvs_port_arb

Interface
REQ-001 SHALL have parameter NPORT, default 2, meaning the number of Ethernet request ports (2..8).
REQ-002 SHALL have parameter KEY_SIZE, default 96, meaning the key width in bits.
REQ-003 SHALL have parameter FLAG_SIZE, default 4, meaning the flag width in bits.
REQ-004 SHALL have parameter TAG_DEPTH, default 16, meaning the outstanding-request tag FIFO depth (power of 2, 4..64).
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port in_key, input, NPORT*KEY_SIZE, the per-port keys; port p occupies bits [p*KEY_SIZE +: KEY_SIZE].
REQ-008 SHALL have port in_flag, input, NPORT*FLAG_SIZE, the per-port request flags.
REQ-009 SHALL have port in_valid, input, NPORT, the per-port request valid.
REQ-010 SHALL have port in_ready, output, NPORT, the per-port accept.
REQ-011 SHALL have port db_key, output, KEY_SIZE, the key to the database.
REQ-012 SHALL have port db_flag, output, FLAG_SIZE, the flag to the database.
REQ-013 SHALL have port db_valid, output, 1, the database request strobe.
REQ-014 SHALL have port db_out_valid, input, 1, the database result strobe; results return in request order.
REQ-015 SHALL have port db_out_flag, input, FLAG_SIZE, the database result flag.
REQ-016 SHALL have port out_valid, output, NPORT, the per-port result strobe.
REQ-017 SHALL have port out_flag, output, NPORT*FLAG_SIZE, the per-port result flag.
REQ-018 SHALL have port err_orphan, output, 1, a sticky flag meaning a result arrived with no outstanding tag.
REQ-019 SHALL have port req_cnt, output, NPORT*32, the per-port accepted-request counters.

Function
REQ-020 A request on port p SHALL transfer in the cycle where in_valid[p] and in_ready[p] are both high.
REQ-021 in_ready SHALL be one-hot or zero: it is high only for the round-robin winner, and only while the tag FIFO count is below TAG_DEPTH.
REQ-022 The round-robin search SHALL start at rr_ptr; after a transfer from port p, rr_ptr SHALL become (p+1) mod NPORT; with no transfer, rr_ptr SHALL hold.
REQ-023 in_ready SHALL be combinational from in_valid, rr_ptr and the registered FIFO count; it SHALL NOT depend on db_out_valid.
REQ-024 For each transfer, db_key, db_flag and db_valid SHALL be registered: db_valid is high for exactly one cycle, one cycle after the transfer.
REQ-025 db_key and db_flag SHALL hold their last value while db_valid is low.
REQ-026 Each transfer SHALL push the winning port index into the tag FIFO in the same cycle.
REQ-027 On db_out_valid with the FIFO non-empty, the block SHALL pop the head tag t and drive out_valid[t]=1 and out_flag[t]=db_out_flag, registered, one cycle later.
REQ-028 While out_valid[t] is low, out_flag[t] SHALL hold its value.
REQ-029 On db_out_valid with the FIFO empty, the block SHALL drive no out_valid, SHALL leave the count unchanged, and SHALL set err_orphan, which stays set until reset.
REQ-030 A simultaneous push and pop SHALL leave the count unchanged; this is legal even when count equals TAG_DEPTH-1.
REQ-031 When count equals TAG_DEPTH, no push SHALL occur; a pop in that cycle SHALL re-enable in_ready from the next cycle.
REQ-032 FIFO pointers SHALL be log2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH; the count SHALL be log2(TAG_DEPTH)+1 bits.

Reset
REQ-033 While rst_n is low, all registers SHALL clear asynchronously: db_valid=0, db_key=0, db_flag=0, out_valid=0, out_flag=0, err_orphan=0, rr_ptr=0, FIFO count and pointers=0, req_cnt=0.
REQ-034 While rst_n is low, in_ready SHALL be 0.
REQ-035 A reset in the middle of operation SHALL discard all outstanding tags; results returned after reset SHALL set err_orphan.

Configuration
REQ-036 With macro KVS_ARB_STATS_EN defined, req_cnt[p] SHALL increment on each transfer from port p and saturate at 32'hFFFFFFFF.
REQ-037 Without KVS_ARB_STATS_EN, req_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-038 NPORT=2, both in_valid held high, db result 3 cycles later -> grants alternate 0,1,0,1; db_valid is one cycle after each grant; out_valid follows the same port order.
REQ-039 TAG_DEPTH=4, no results, port 0 valid -> 4 transfers, then in_ready=0; one db_out_valid -> in_ready=1 in the next cycle.
REQ-040 db_out_valid with db_out_flag=4'hA and no requests -> no out_valid; err_orphan=1 and stays set.
REQ-041 Count=3 with simultaneous push and pop -> count stays 3, and both the out_valid and the db_valid fire.
REQ-042 rst_n low with 2 outstanding tags, then released -> all outputs are 0; the next result sets err_orphan.
REQ-043 KVS_ARB_STATS_EN defined, 5 transfers from port 1 -> req_cnt[63:32]=5 and req_cnt[31:0]=0; macro undefined -> req_cnt=0.
